tilt_gesture_debounce: RTL

//  Consumes 2-bit tilt codes from the tilt custom-instruction unit (result qualified by done).

---
 rtl/tilt_gesture_debounce.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/tilt_gesture_debounce.sv
// Tilt gesture debouncer: a sustained non-neutral tilt code fires one event, the board must
// return to neutral before re-arming, and events queue in a first-word-fall-through FIFO.
module tilt_gesture_debounce #(
    parameter int HOLD_SAMPLES  = 8,
    parameter int REARM_SAMPLES = 4,
    parameter int CNT_W         = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int PTR_W         = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tilt_valid,
    input  logic [1:0]       tilt_code,
    input  logic             evt_ready,
    input  logic             clear_overflow,
    output logic             evt_valid,
    output logic [1:0]       evt_code,
    output logic [PTR_W:0]   evt_level,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        TRACK   = 2'b01,
        LATCHED = 2'b10
    } state_t;

    state_t           state, state_next;
    logic [1:0]       cand, cand_next;
    logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
    logic [CNT_W-1:0] rcnt, rcnt_next, rcnt_inc;
    logic             fire;

    logic [1:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_next, wr_next;
    logic [PTR_W:0]   level_next;
    logic             pop, full, do_push, drop;
    logic [1:0]       head_next;

    assign cnt_inc  = cnt + CNT_W'(1);
    assign rcnt_inc = rcnt + CNT_W'(1);

    // Gesture FSM next-state: only qualified samples advance it.
    always_comb begin
        state_next = state;
        cand_next  = cand;
        cnt_next   = cnt;
        rcnt_next  = rcnt;
        fire       = 1'b0;
        if (tilt_valid) begin
            case (state)
                IDLE: begin
                    if (tilt_code != 2'b00) begin
                        cand_next  = tilt_code;
                        cnt_next   = CNT_W'(1);
                        state_next = TRACK;
                    end else begin
                        state_next = IDLE;
                    end
                end
                TRACK: begin
                    if (tilt_code == cand) begin
                        if (cnt_inc == CNT_W'(HOLD_SAMPLES)) begin
                            fire       = 1'b1;
                            rcnt_next  = CNT_W'(0);
                            state_next = LATCHED;
                        end else begin
                            cnt_next = cnt_inc;
                        end
                    end else if (tilt_code == 2'b00) begin
                        state_next = IDLE;
                    end else begin
                        cand_next = tilt_code;
                        cnt_next  = CNT_W'(1);
                    end
                end
                LATCHED: begin
                    if (tilt_code == 2'b00) begin
                        rcnt_next = rcnt_inc;
                        if (rcnt_inc == CNT_W'(REARM_SAMPLES)) begin
                            state_next = IDLE;
                        end else begin
                            state_next = LATCHED;
                        end
                    end else begin
                        rcnt_next = CNT_W'(0);
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end else begin
            state_next = state;
        end
    end

    // FIFO control; a full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        pop        = evt_valid & evt_ready;
        full       = (evt_level == (PTR_W+1)'(FIFO_DEPTH));
        do_push    = fire & (~full | pop);
        drop       = fire & full & ~pop;
        level_next = evt_level + (PTR_W+1)'(do_push) - (PTR_W+1)'(pop);
        rd_next    = rd_ptr + PTR_W'(pop);
        wr_next    = wr_ptr + PTR_W'(do_push);
        if (level_next == (PTR_W+1)'(0)) begin
            head_next = 2'b00;
        end else if (do_push && (rd_next == wr_ptr)) begin
            head_next = cand;
        end else begin
            head_next = mem[rd_next];
        end
    end

    // State, counters, pointers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cand      <= 2'b00;
            cnt       <= CNT_W'(0);
            rcnt      <= CNT_W'(0);
            wr_ptr    <= PTR_W'(0);
            rd_ptr    <= PTR_W'(0);
            evt_level <= (PTR_W+1)'(0);
            evt_valid <= 1'b0;
            evt_code  <= 2'b00;
            overflow  <= 1'b0;
        end else begin
            state     <= state_next;
            cand      <= cand_next;
            cnt       <= cnt_next;
            rcnt      <= rcnt_next;
            wr_ptr    <= wr_next;
            rd_ptr    <= rd_next;
            evt_level <= level_next;
            evt_valid <= (level_next != (PTR_W+1)'(0));
            evt_code  <= head_next;
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    // Event storage; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= cand;
        end
    end

endmodule
